// File: rtl/serial_adder.sv
// serial_adder: bit-serial a+b+cin adder, LSB first, one bit per clock,
// with a valid/ready handshake on both operand and result sides.
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    bit_cnt;

  logic ha1_s, ha1_c, ha2_s, ha2_c, carry_nxt;

  // Full adder built from two cascaded half adders.
  always_comb begin
    ha1_s     = a_sh[0] ^ b_sh[0];
    ha1_c     = a_sh[0] & b_sh[0];
    ha2_s     = ha1_s ^ carry;
    ha2_c     = ha1_s & carry;
    carry_nxt = ha1_c | ha2_c;
  end

  assign sum = sum_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      bit_cnt   <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= cin;
            bit_cnt  <= '0;
            sum_sh   <= '0;
            state    <= ADD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ADD: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          sum_sh  <= (sum_sh >> 1) | (WIDTH'(ha2_s) << (WIDTH - 1));
          carry   <= carry_nxt;
          bit_cnt <= bit_cnt + CW'(1);
          // On the MSB, the carry flop still holds the carry into the MSB.
          if (bit_cnt == LAST_BIT) begin
            cout      <= carry_nxt;
            ovf       <= carry ^ carry_nxt;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH = 8, 1 and 13.
`default_nettype none

module tb_serial_adder;

  logic        clk;
  logic        rst_n;
  logic [2:0]  in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
  logic [63:0] a_d [3];
  logic [63:0] b_d [3];
  logic [7:0]  sum8;
  logic [0:0]  sum1;
  logic [12:0] sum13;

  typedef struct {
    int          k;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_d[0][7:0]), .b(b_d[0][7:0]), .cin(cin[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .sum(sum8), .cout(cout[0]), .ovf(ovf[0]), .busy(busy[0])
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_d[1][0:0]), .b(b_d[1][0:0]), .cin(cin[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .sum(sum1), .cout(cout[1]), .ovf(ovf[1]), .busy(busy[1])
  );

  serial_adder #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_d[2][12:0]), .b(b_d[2][12:0]), .cin(cin[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .sum(sum13), .cout(cout[2]), .ovf(ovf[2]), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int width_of(input int k);
    case (k)
      0:       return 8;
      1:       return 1;
      default: return 13;
    endcase
  endfunction

  function automatic logic [63:0] sum_of(input int k);
    case (k)
      0:       return 64'(sum8);
      1:       return 64'(sum1);
      default: return 64'(sum13);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected result per completed output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: inst %0d presented sum 0x%0h, expected no result", k, sum_of(k));
          end else begin
            mon_e = sbq.pop_front();
            check("sb_inst", 64'(k), 64'(mon_e.k));
            check("sb_sum", sum_of(k), mon_e.sum);
            check("sb_cout", 64'(cout[k]), 64'(mon_e.cout));
            check("sb_ovf", 64'(ovf[k]), 64'(mon_e.ovf));
          end
        end
      end
    end
  end

  // Issue one operation; garbage operands with in_valid high are driven while
  // the block is busy and must be ignored. hold>0 stalls out_ready in DONE.
  task automatic run_op(input int k, input logic [63:0] av, input logic [63:0] bv, input logic ci,
                        input logic [63:0] es, input logic ec, input logic eo, input int hold);
    int   g;
    int   lat;
    exp_t e;
    a_d[k]       = av;
    b_d[k]       = bv;
    cin[k]       = ci;
    in_valid[k]  = 1'b1;
    out_ready[k] = (hold == 0);
    g = 0;
    while (!in_ready[k] && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check("in_ready_wait", 64'(in_ready[k]), 64'd1);
    @(posedge clk);
    e.k = k; e.sum = es; e.cout = ec; e.ovf = eo;
    sbq.push_back(e);
    #1;
    a_d[k] = 64'h11;
    b_d[k] = 64'h11;
    cin[k] = 1'b1;
    check("in_ready_busy", 64'(in_ready[k]), 64'd0);
    lat = 0;
    while (!out_valid[k] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(width_of(k)));
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 64'(out_valid[k]), 64'd1);
      check("hold_sum", sum_of(k), es);
      check("hold_cout", 64'(cout[k]), 64'(ec));
      check("hold_in_ready", 64'(in_ready[k]), 64'd0);
      @(posedge clk); #1;
    end
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 64'(in_ready[k]), 64'd1);
    check("idle_busy", 64'(busy[k]), 64'd0);
    check("idle_out_valid", 64'(out_valid[k]), 64'd0);
    check("idle_sum_kept", sum_of(k), es);
    in_valid[k] = 1'b0;
  endtask

  task automatic rand_ops(input int k, input int n);
    int          w;
    logic [63:0] mask, av, bv, s;
    logic [64:0] full;
    logic        ci, co, ov;
    w    = width_of(k);
    mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < n; i++) begin
      av   = {$urandom, $urandom} & mask;
      bv   = {$urandom, $urandom} & mask;
      ci   = 1'($urandom);
      full = 65'(av) + 65'(bv) + 65'(ci);
      s    = full[63:0] & mask;
      co   = full[w];
      ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
      run_op(k, av, bv, ci, s, co, ov, 0);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = '0;
    cin       = '0;
    out_ready = 3'b111;
    for (int k = 0; k < 3; k++) begin
      a_d[k] = '0;
      b_d[k] = '0;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready", 64'(in_ready[k]), 64'd1);
      check("rst_out_valid", 64'(out_valid[k]), 64'd0);
      check("rst_busy", 64'(busy[k]), 64'd0);
      check("rst_sum", sum_of(k), 64'd0);
      check("rst_cout", 64'(cout[k]), 64'd0);
      check("rst_ovf", 64'(ovf[k]), 64'd0);
    end
    #23 rst_n = 1'b1;

    // WIDTH=8 directed vectors
    run_op(0, 64'h00, 64'h00, 1'b0, 64'h00, 1'b0, 1'b0, 0);
    run_op(0, 64'hFF, 64'h01, 1'b0, 64'h00, 1'b1, 1'b0, 0);
    run_op(0, 64'h7F, 64'h01, 1'b0, 64'h80, 1'b0, 1'b1, 0);
    run_op(0, 64'hA5, 64'h5A, 1'b1, 64'h00, 1'b1, 1'b0, 5);
    run_op(0, 64'h03, 64'h04, 1'b0, 64'h07, 1'b0, 1'b0, 0);
    run_op(0, 64'h80, 64'h80, 1'b0, 64'h00, 1'b1, 1'b1, 0);

    // Abort mid-add with reset; the aborted result must never appear.
    a_d[0] = 64'h12; b_d[0] = 64'h34; cin[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_sum", 64'(sum8), 64'd0);
    check("abort_cout", 64'(cout[0]), 64'd0);
    check("abort_ovf", 64'(ovf[0]), 64'd0);
    check("abort_out_valid", 64'(out_valid[0]), 64'd0);
    check("abort_in_ready", 64'(in_ready[0]), 64'd1);
    check("abort_busy", 64'(busy[0]), 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", 64'(out_valid[0]), 64'd0);
    end
    run_op(0, 64'h10, 64'h20, 1'b0, 64'h30, 1'b0, 1'b0, 0);

    // WIDTH=1 directed vectors
    run_op(1, 64'h1, 64'h1, 1'b1, 64'h1, 1'b1, 1'b0, 0);
    run_op(1, 64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b1, 0);
    run_op(1, 64'h1, 64'h0, 1'b0, 64'h1, 1'b0, 1'b0, 2);

    // WIDTH=13 directed vectors
    run_op(2, 64'h1FFF, 64'h0001, 1'b0, 64'h0000, 1'b1, 1'b0, 0);
    run_op(2, 64'h0FFF, 64'h0001, 1'b0, 64'h1000, 1'b0, 1'b1, 0);
    run_op(2, 64'h1000, 64'h1000, 1'b1, 64'h0001, 1'b1, 1'b1, 3);

    rand_ops(0, 1000);
    rand_ops(1, 1000);
    rand_ops(2, 1000);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand and sum width in bits; legal range 1..64.
REQ-002 SHALL provide port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL provide port in_valid  input  1  operands a, b, cin valid this cycle.
REQ-005 SHALL provide port in_ready  output  1  block can accept operands.
REQ-006 SHALL provide port a  input  WIDTH  unsigned/two's-complement operand A.
REQ-007 SHALL provide port b  input  WIDTH  operand B.
REQ-008 SHALL provide port cin  input  1  carry-in.
REQ-009 SHALL provide port out_valid  output  1  result valid.
REQ-010 SHALL provide port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL provide port sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
REQ-012 SHALL provide port cout  output  1  carry out of bit WIDTH-1.
REQ-013 SHALL provide port ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).
REQ-014 SHALL provide port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement three states: IDLE, ADD, DONE.
REQ-016 IDLE: in_ready=1, out_valid=0; accept on rising edge with in_valid&&in_ready: load a, b into shift registers, carry flop <= cin, bit counter <= 0, clear sum register, go to ADD.
REQ-017 IDLE with in_valid=0: stay in IDLE, no register change.
REQ-018 ADD: one bit per cycle, LSB first; sum bit = a0^b0^c (two cascaded half-add stages), carry flop <= a0&b0 | c&(a0^b0); shift a, b right; shift sum bit into sum register MSB side.
REQ-019 ADD: on the cycle processing bit WIDTH-1, capture carry-into-MSB for ovf, update cout, go to DONE.
REQ-020 Latency: out_valid SHALL rise exactly WIDTH rising edges after the accepting edge; throughput one result per WIDTH+2 cycles with out_ready held high.
REQ-021 DONE: out_valid=1; sum, cout, ovf stable until handshake; on edge with out_ready=1 go to IDLE; out_ready=0 holds DONE indefinitely.
REQ-022 in_ready SHALL be 0 in ADD and DONE; in_valid and operand changes there SHALL be ignored.
REQ-023 No same-cycle turnaround: operands SHALL NOT be accepted on the DONE->IDLE edge.
REQ-024 out_ready outside DONE SHALL have no effect.
REQ-025 sum, cout, ovf SHALL retain the last result in IDLE until the next acceptance, and are undefined-for-use (but deterministic) during ADD.
REQ-026 WIDTH=1: ADD lasts one cycle; ovf = cin XOR cout.
REQ-027 Bit counter width SHALL be clog2(WIDTH)+1 bits; no wrap-around permitted within one operation.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, carry flop=0, counter=0, independent of clk.
REQ-029 Reset asserted mid-ADD or mid-DONE SHALL abort the operation; no out_valid for that operation after release.
REQ-030 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 WIDTH=8, a=0x00, b=0x00, cin=0, out_ready=1 -> after 8 edges out_valid=1, sum=0x00, cout=0, ovf=0.
REQ-032 WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-033 WIDTH=8, a=0xA5, b=0x5A, cin=1, out_ready=0 for 5 cycles after out_valid -> sum=0x00, cout=1 held stable 5 cycles, in_ready=0 throughout, IDLE one cycle after out_ready=1.
REQ-034 in_valid pulsed with a=0x11 during ADD of a=0x03+b=0x04 -> result 0x07, second operand set never loaded.
REQ-035 rst_n pulled low at bit 3 of an 8-bit add -> outputs zero immediately, out_valid stays 0 after release, next add 0x10+0x20 returns 0x30 correctly.
REQ-036 WIDTH=1, a=1, b=1, cin=1 -> out_valid after 1 edge, sum=1, cout=1, ovf=0; random 1000-op sweep at WIDTH=1, 8, 13 against a+b+cin reference model.
